// File: rtl/axi4lite_cfg_pkg.sv
// Shared constants and state encodings for the AXI4-Lite configuration register slave.
// Pure definitions: no logic, no latency, no flow control.
package axi4lite_cfg_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int REG0_IDX = 0;
   localparam int REG1_IDX = 1;
   localparam int REG2_IDX = 2;
   localparam int REG3_IDX = 3;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

endpackage

// File: rtl/axi4lite_cfg_reg_slave_if.sv
// AXI4-Lite bus bundle between a master (VIP/PS) and the configuration register slave.
// Signal bundle only: latency and backpressure are set by the connected endpoints.
interface axi4lite_cfg_reg_slave_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/axi4lite_wstrb_merge.sv
// Byte-enable merge of new write data into an existing register value.
// Purely combinational, zero latency, no flow control.
module axi4lite_wstrb_merge #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   old_val,
   input  logic [DW-1:0]   new_val,
   input  logic [DW/8-1:0] strb,
   output logic [DW-1:0]   merged
);

   always_comb begin
      merged = old_val;
      for (int b = 0; b < DW/8; b++) begin
         if (strb[b]) begin
            merged[b*8 +: 8] = new_val[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/axi4lite_cfg_reg_slave.sv
// AXI4-Lite slave holding NUM_REGS config registers; B/R valid one cycle after the last address/data handshake.
// One outstanding transaction per channel: AW/W and AR stay unready until the pending B or R is accepted.
module axi4lite_cfg_reg_slave
   import axi4lite_cfg_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_REGS           = 4
) (
   input  logic                                    ACLK,
   input  logic                                    ARESETN,
   axi4lite_cfg_reg_slave_if.slave                 s_axi,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  cfg_reg_o,
   output logic [NUM_REGS-1:0]                     cfg_wr_pulse_o
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int SW = DW/8;
   localparam int IW = AW-2;

   // Held low through reset so no READY is seen until the first clock after release.
   logic                         live;
   w_state_t                     w_state, w_state_nxt;
   r_state_t                     r_state, r_state_nxt;
   logic [NUM_REGS-1:0][DW-1:0]  regs;
   logic                         aw_held, w_held;
   logic [IW-1:0]                awidx_q;
   logic [DW-1:0]                wdata_q;
   logic [SW-1:0]                wstrb_q;
   logic [1:0]                   bresp_q, rresp_q;
   logic [DW-1:0]                rdata_q;

   logic                         awready, wready, arready;
   logic                         aw_fire, w_fire, ar_fire, wr_go;
   logic [IW-1:0]                wr_idx, rd_idx;
   logic [DW-1:0]                wr_data, old_val, merged, rd_val;
   logic [SW-1:0]                wr_strb;
   logic                         wr_hit, rd_hit;
   logic [NUM_REGS-1:0]          wr_sel;
   logic                         unused_bits;

   assign awready = live && (w_state == W_IDLE) && !aw_held;
   assign wready  = live && (w_state == W_IDLE) && !w_held;
   assign arready = live && (r_state == R_IDLE);
   assign aw_fire = s_axi.S_AXI_AWVALID && awready;
   assign w_fire  = s_axi.S_AXI_WVALID && wready;
   assign ar_fire = s_axi.S_AXI_ARVALID && arready;

   assign s_axi.S_AXI_AWREADY = awready;
   assign s_axi.S_AXI_WREADY  = wready;
   assign s_axi.S_AXI_ARREADY = arready;
   assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign cfg_reg_o           = regs;

   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   // A channel captured on this very cycle is used straight from the bus.
   always_comb begin
      wr_idx  = aw_held ? awidx_q : s_axi.S_AXI_AWADDR[AW-1:2];
      wr_data = w_held ? wdata_q : s_axi.S_AXI_WDATA;
      wr_strb = w_held ? wstrb_q : s_axi.S_AXI_WSTRB;
      wr_hit  = (int'(wr_idx) < NUM_REGS);
      old_val = '0;
      wr_sel  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (wr_idx == IW'(k)) begin
            old_val   = regs[k];
            wr_sel[k] = |wr_strb;
         end
      end
   end

   axi4lite_wstrb_merge #(.DW(DW)) u_merge (
      .old_val (old_val),
      .new_val (wr_data),
      .strb    (wr_strb),
      .merged  (merged)
   );

   always_comb begin
      rd_idx = s_axi.S_AXI_ARADDR[AW-1:2];
      rd_hit = (int'(rd_idx) < NUM_REGS);
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rd_idx == IW'(k)) begin
            rd_val = regs[k];
         end
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      wr_go       = 1'b0;
      case (w_state)
         W_IDLE: begin
            if ((aw_held || aw_fire) && (w_held || w_fire)) begin
               wr_go       = 1'b1;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               w_state_nxt = W_IDLE;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         live           <= 1'b0;
         w_state        <= W_IDLE;
         aw_held        <= 1'b0;
         w_held         <= 1'b0;
         awidx_q        <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         bresp_q        <= '0;
         regs           <= '0;
         cfg_wr_pulse_o <= '0;
      end else begin
         live           <= 1'b1;
         w_state        <= w_state_nxt;
         cfg_wr_pulse_o <= wr_go ? wr_sel : '0;
         if (aw_fire) begin
            aw_held <= 1'b1;
            awidx_q <= s_axi.S_AXI_AWADDR[AW-1:2];
         end
         if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
         end
         if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
               if (wr_sel[k]) begin
                  regs[k] <= merged;
               end
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= '0;
      end else begin
         r_state <= r_state_nxt;
         if (ar_fire) begin
            rdata_q <= rd_hit ? rd_val : '0;
            rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_cfg_reg_slave.sv
// Directed self-checking bench for axi4lite_cfg_reg_slave; inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_cfg_reg_slave;
   import axi4lite_cfg_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi4lite_cfg_reg_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();
   logic [127:0] cfg_reg;
   logic [3:0]   cfg_pulse;

   axi4lite_cfg_reg_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (5),
      .NUM_REGS           (4)
   ) dut (
      .ACLK           (clk),
      .ARESETN        (rst_n),
      .s_axi          (bus),
      .cfg_reg_o      (cfg_reg),
      .cfg_wr_pulse_o (cfg_pulse)
   );

   int checks = 0;
   int errors = 0;
   int pulse_cnt [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) if (cfg_pulse[k] === 1'b1) pulse_cnt[k]++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     output logic [1:0] resp);
      bit a_done, w_done, a_f, w_f;
      int t;
      @(negedge clk);
      bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = data;  bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_BREADY = 1'b1;
      a_done = 0; w_done = 0; t = 0;
      while (!(a_done && w_done) && t < 50) begin
         a_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w_f = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         @(negedge clk);
         if (a_f) begin bus.S_AXI_AWVALID = 1'b0; a_done = 1; end
         if (w_f) begin bus.S_AXI_WVALID = 1'b0; w_done = 1; end
         t++;
      end
      t = 0;
      while (bus.S_AXI_BVALID !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1) begin
         errors++;
         $display("FAIL wr_bvalid addr=%h: bvalid=%b required 1", addr, bus.S_AXI_BVALID);
      end
      resp = bus.S_AXI_BRESP;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                     output logic prompt);
      bit f;
      int t;
      @(negedge clk);
      bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
      f = 0; t = 0;
      while (!f && t < 50) begin f = bus.S_AXI_ARREADY; @(negedge clk); t++; end
      bus.S_AXI_ARVALID = 1'b0;
      prompt = bus.S_AXI_RVALID;
      t = 0;
      while (bus.S_AXI_RVALID !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (bus.S_AXI_RVALID !== 1'b1) begin
         errors++;
         $display("FAIL rd_rvalid addr=%h: rvalid=%b required 1", addr, bus.S_AXI_RVALID);
      end
      data = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
         errors++;
         $display("FAIL reset_handshake: aw/w/ar rdy,b/r vld=%b required 00000",
                  {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
      end
      checks++;
      if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== 36'h0) begin
         errors++;
         $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h required 0", bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
      end
      checks++;
      if (cfg_reg !== 128'h0 || cfg_pulse !== 4'h0) begin
         errors++;
         $display("FAIL reset_cfg: cfg_reg=%h pulse=%b required 0", cfg_reg, cfg_pulse);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL post_reset_ready: aw/w/ar rdy=%b required 111",
                  {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
   endtask

   task automatic test_basic_rw();
      logic [1:0]  resp;
      logic [31:0] data;
      logic        prompt;
      int          p0 [4];
      int          idx [4];
      idx = '{REG0_IDX, REG1_IDX, REG2_IDX, REG3_IDX};
      for (int i = 0; i < 4; i++) p0[i] = pulse_cnt[i];
      for (int i = 0; i < 4; i++) begin
         wr(5'(idx[i] * 4), 32'(i + 1), 4'hF, resp);
         checks++;
         if (resp !== RESP_OKAY) begin errors++; $display("FAIL basic_bresp[%0d]: got %b required 00", i, resp); end
      end
      checks++;
      if (cfg_reg !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
         errors++;
         $display("FAIL basic_cfg_reg: got %h required 00000004000000030000000200000001", cfg_reg);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pulse_cnt[i] - p0[i] !== 1) begin
            errors++;
            $display("FAIL basic_pulse[%0d]: count %0d required 1", i, pulse_cnt[i] - p0[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         rd(5'(i * 4), data, resp, prompt);
         checks++;
         if (data !== 32'(i + 1) || resp !== RESP_OKAY || prompt !== 1'b1) begin
            errors++;
            $display("FAIL basic_read[%0d]: data=%h resp=%b prompt=%b required %h 00 1", i, data, resp, prompt, i + 1);
         end
      end
   endtask

   task automatic test_aw_before_w();
      int t;
      @(negedge clk);
      bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
      t = 0;
      while (bus.S_AXI_AWREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b010) begin
         errors++;
         $display("FAIL awfirst_wait: awrdy,wrdy,bvld=%b required 010",
                  {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID});
      end
      bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_WVALID = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== RESP_OKAY) begin
         errors++;
         $display("FAIL awfirst_b_latency: bvalid=%b bresp=%b required 1 00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
      end
      checks++;
      if (cfg_reg[63:32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL awfirst_reg1: got %h required deadbeef", cfg_reg[63:32]);
      end
      @(negedge clk);
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin
         errors++;
         $display("FAIL awfirst_b_done: bvalid=%b required 0", bus.S_AXI_BVALID);
      end
   endtask

   task automatic test_strobes();
      logic [1:0]  resp;
      logic [31:0] data;
      logic        prompt;
      int          p;
      wr(5'h08, 32'hFFFFFFFF, 4'hF, resp);
      p = pulse_cnt[2];
      wr(5'h08, 32'h12345678, 4'b0101, resp);
      checks++;
      if (cfg_reg[95:64] !== 32'hFF34FF78 || resp !== RESP_OKAY || pulse_cnt[2] - p !== 1) begin
         errors++;
         $display("FAIL strobe_merge: reg2=%h resp=%b pulses=%0d required ff34ff78 00 1",
                  cfg_reg[95:64], resp, pulse_cnt[2] - p);
      end
      p = pulse_cnt[2];
      wr(5'h08, 32'hAAAAAAAA, 4'b0000, resp);
      checks++;
      if (cfg_reg[95:64] !== 32'hFF34FF78 || resp !== RESP_OKAY || pulse_cnt[2] - p !== 0) begin
         errors++;
         $display("FAIL strobe_zero: reg2=%h resp=%b pulses=%0d required ff34ff78 00 0",
                  cfg_reg[95:64], resp, pulse_cnt[2] - p);
      end
      rd(5'h08, data, resp, prompt);
      checks++;
      if (data !== 32'hFF34FF78) begin
         errors++;
         $display("FAIL strobe_readback: got %h required ff34ff78", data);
      end
   endtask

   task automatic test_slverr();
      logic [1:0]  resp;
      logic [31:0] data;
      logic        prompt;
      int          p [4];
      for (int i = 0; i < 4; i++) p[i] = pulse_cnt[i];
      wr(5'h14, 32'hCAFEF00D, 4'hF, resp);
      checks++;
      if (resp !== RESP_SLVERR) begin errors++; $display("FAIL slverr_bresp: got %b required 10", resp); end
      checks++;
      if (cfg_reg !== {32'h4, 32'hFF34FF78, 32'hDEADBEEF, 32'h1}) begin
         errors++;
         $display("FAIL slverr_regs: got %h required 00000004ff34ff78deadbeef00000001", cfg_reg);
      end
      checks++;
      if (pulse_cnt[0] != p[0] || pulse_cnt[1] != p[1] || pulse_cnt[2] != p[2] || pulse_cnt[3] != p[3]) begin
         errors++;
         $display("FAIL slverr_pulse: pulses seen on an out-of-range write, required none");
      end
      rd(5'h14, data, resp, prompt);
      checks++;
      if (data !== 32'h0 || resp !== RESP_SLVERR || prompt !== 1'b1) begin
         errors++;
         $display("FAIL slverr_read: data=%h resp=%b prompt=%b required 0 10 1", data, resp, prompt);
      end
      rd(5'h1C, data, resp, prompt);
      checks++;
      if (data !== 32'h0 || resp !== RESP_SLVERR) begin
         errors++;
         $display("FAIL slverr_read_top: data=%h resp=%b required 0 10", data, resp);
      end
   endtask

   task automatic test_rw_same_cycle();
      logic [1:0]  wresp, rresp;
      logic [31:0] data;
      logic        prompt;
      fork
         wr(5'h00, 32'hA5A5A5A5, 4'hF, wresp);
         rd(5'h00, data, rresp, prompt);
      join
      checks++;
      if (data !== 32'h1 || rresp !== RESP_OKAY) begin
         errors++;
         $display("FAIL same_cycle_read: data=%h resp=%b required 00000001 00", data, rresp);
      end
      checks++;
      if (cfg_reg[31:0] !== 32'hA5A5A5A5 || wresp !== RESP_OKAY) begin
         errors++;
         $display("FAIL same_cycle_write: reg0=%h resp=%b required a5a5a5a5 00", cfg_reg[31:0], wresp);
      end
   endtask

   task automatic test_backpressure();
      int t;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'h11111111; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_WDATA = 32'h22222222;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin
            errors++;
            $display("FAIL bp_hold[%0d]: bvld,awrdy,wrdy=%b required 100", i,
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
         end
         @(negedge clk);
      end
      checks++;
      if (cfg_reg[31:0] !== 32'h11111111 || cfg_reg[127:96] !== 32'h4) begin
         errors++;
         $display("FAIL bp_regs_held: reg0=%h reg3=%h required 11111111 00000004", cfg_reg[31:0], cfg_reg[127:96]);
      end
      bus.S_AXI_BREADY = 1'b1;
      t = 0;
      @(negedge clk);
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1 || cfg_reg[127:96] !== 32'h22222222 || bus.S_AXI_BRESP !== RESP_OKAY) begin
         errors++;
         $display("FAIL bp_second_write: bvalid=%b reg3=%h bresp=%b required 1 22222222 00",
                  bus.S_AXI_BVALID, cfg_reg[127:96], bus.S_AXI_BRESP);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      logic [1:0] resp;
      int t;
      @(negedge clk);
      bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
      t = 0;
      while (bus.S_AXI_AWREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0
          || bus.S_AXI_BRESP !== 2'b0 || cfg_pulse !== 4'h0) begin
         errors++;
         $display("FAIL midreset_outputs: rdy/vld=%b bresp=%b pulse=%b required 0",
                  {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID},
                  bus.S_AXI_BRESP, cfg_pulse);
      end
      checks++;
      if (cfg_reg !== 128'h0) begin
         errors++;
         $display("FAIL midreset_regs: got %h required 0", cfg_reg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr(5'h0C, 32'h0BADCAFE, 4'hF, resp);
      checks++;
      if (resp !== RESP_OKAY || cfg_reg !== {32'h0BADCAFE, 96'h0}) begin
         errors++;
         $display("FAIL midreset_next_write: resp=%b cfg_reg=%h required 00 0badcafe000000000000000000000000",
                  resp, cfg_reg);
      end
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_aw_before_w();
      test_strobes();
      test_slverr();
      test_rw_same_cycle();
      test_backpressure();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4lite_cfg_reg_slave.md
Name: axi4lite_cfg_reg_slave

Overview:
- AXI4-Lite slave register file that terminates the master VIP/PS transactions of the BCM IP.
- Holds four 32-bit read/write configuration registers. Exposes them, plus per-register write-strobe pulses, to the downstream BCM logic.
- Decodes byte addresses 0x00..0x1C. 0x00..0x0C map to REG0..REG3. 0x10..0x1C return SLVERR.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [1:0] are ignored.
- NUM_REGS, 4, number of implemented registers; must be at most 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write-response handshake
- S_AXI_ARADDR  in  5  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read-data handshake
- cfg_reg_o  out  NUM_REGS*32  current register contents, REG0 in LSBs
- cfg_wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after a register is updated

Behaviour:
- Reset:
  - Asserting ARESETN low asynchronously clears all registers to 0.
  - All READY/VALID outputs go to 0; BRESP, RRESP, RDATA go to 0; cfg_wr_pulse_o goes to 0.
  - A transaction in flight at reset is dropped with no response.
- Write channel FSM with states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY=1 until AW has been captured, and WREADY=1 until W has been captured. AW and W may arrive in either order or together; each is latched independently.
  - When both are held, on that same cycle:
    - If the address decodes to a register, update it byte-wise per WSTRB and set BRESP=OKAY.
    - Otherwise no state changes and BRESP=SLVERR.
  - Then BVALID=1, enter W_RESP, and deassert AWREADY/WREADY.
  - W_RESP holds BVALID and BRESP until the BVALID&&BREADY handshake, then returns to W_IDLE.
  - Best-case latency: AW+W on cycle N gives BVALID on cycle N+1.
  - WSTRB=0 with a valid address returns OKAY, leaves the register unchanged and raises no pulse.
- Write pulse: cfg_wr_pulse_o[k]=1 for exactly one cycle, the cycle on which BVALID first rises, when REG k was written with a nonzero WSTRB.
- Read channel FSM with states R_IDLE, R_DATA:
  - In R_IDLE, ARREADY=1. On ARVALID, capture the address and register the data/response: register value with OKAY, or 0 with SLVERR for an out-of-range address.
  - Set RVALID=1 on the next cycle and enter R_DATA.
  - R_DATA holds RDATA and RRESP stable until RREADY, then returns to R_IDLE.
  - Latency: AR on cycle N gives RVALID on cycle N+1.
- Simultaneous read and write to the same register on the same cycle: the read returns the pre-write value.
- Read and write channels are fully independent. One outstanding transaction per channel.
- Backpressure: with BREADY or RREADY held low indefinitely, no new AW/W or AR is accepted on that channel.

Decomposition:
- Package axi4lite_cfg_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - write-state and read-state enums
  - register index constants REG0_IDX..REG3_IDX
- The write-side byte-enable merge is the natural sub-module: axi4lite_wstrb_merge, taking old value, new data and strobe, and returning the merged value.

Test Plan:
- Reset, then write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C; read back -> 0x1..0x4, all BRESP/RRESP=OKAY, cfg_reg_o={4,3,2,1}, each cfg_wr_pulse_o bit pulses exactly once.
- AW presented 3 cycles before W to 0x04 with data 0xDEADBEEF -> BVALID exactly 1 cycle after the W handshake, REG1=0xDEADBEEF.
- REG2=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> REG2=0xFF34FF78; WSTRB=0 -> no change, no pulse, OKAY.
- Write/read at 0x14 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, REG0..REG3 unchanged.
- BREADY held low 10 cycles with a second AW/W pending -> BVALID stays high, AWREADY/WREADY stay 0, second write completes after the release.
- Drop ARESETN mid-write (AW taken, W not yet) -> all outputs 0 immediately, registers 0, next write after reset completes normally.
